seq_multiplier: RTL and testbench

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

---
 rtl/legv8_pkg.sv | 14 +
 rtl/seq_multiplier.sv | 139 +++++++++++++
 tb/tb_seq_multiplier.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/legv8_pkg.sv
// Shared LEGv8 constants and the sequential multiplier FSM state type.
package legv8_pkg;

  localparam int unsigned DataW   = 64;
  localparam int unsigned TagW    = 5;
  localparam int unsigned NumIter = 64;

  typedef logic [1:0] state_t;

  localparam state_t StIdle = 2'd0;
  localparam state_t StRun  = 2'd1;
  localparam state_t StDone = 2'd2;

endpackage

// File: rtl/seq_multiplier.sv
// 64-iteration shift-add unsigned multiplier feeding the LEGv8 register-file write port.
// Define SEQ_MULTIPLIER_MULH_EN to add the High port and keep the full 128-bit product.
module seq_multiplier
  import legv8_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic [DataW-1:0]  BusA,
  input  logic [DataW-1:0]  BusB,
  input  logic [TagW-1:0]   RW,
`ifdef SEQ_MULTIPLIER_MULH_EN
  input  logic              High,
`endif
  output logic [DataW-1:0]  Result,
  output logic [TagW-1:0]   RWOut,
  output logic              Busy,
  output logic              Done
);

`ifdef SEQ_MULTIPLIER_MULH_EN
  localparam int unsigned ProdW = 2 * DataW;
`else
  localparam int unsigned ProdW = DataW;
`endif

  state_t             state_q, state_d;
  logic [6:0]         cnt_q, cnt_d;
  logic [DataW-1:0]   mcand_q, mcand_d;
  logic [DataW-1:0]   mplier_q, mplier_d;
  logic [TagW-1:0]    rw_q, rw_d;
  logic [ProdW-1:0]   prod_q, prod_d;
  logic [DataW-1:0]   result_q, result_d;
  logic [TagW-1:0]    rwout_q, rwout_d;
  logic               done_q, done_d;
  logic [ProdW-1:0]   prod_step;
  logic [DataW-1:0]   prod_sel;

`ifdef SEQ_MULTIPLIER_MULH_EN
  logic               high_q, high_d;
  logic [DataW:0]     sum;

  // Add into the upper half with carry, then shift the whole product right.
  always_comb begin
    sum       = {1'b0, prod_q[ProdW-1:DataW]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
    prod_step = {sum, prod_q[DataW-1:1]};
    prod_sel  = high_q ? prod_q[ProdW-1:DataW] : prod_q[DataW-1:0];
  end
`else
  // Low half only: accumulate a left-shifting multiplicand modulo 2^64.
  always_comb begin
    prod_step = prod_q + (mplier_q[0] ? mcand_q : '0);
    prod_sel  = prod_q;
  end
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    rw_d     = rw_q;
    prod_d   = prod_q;
    result_d = result_q;
    rwout_d  = rwout_q;
`ifdef SEQ_MULTIPLIER_MULH_EN
    high_d   = high_q;
`endif
    case (state_q)
      StIdle: begin
        if (Start) begin
          mcand_d  = BusA;
          mplier_d = BusB;
          rw_d     = RW;
`ifdef SEQ_MULTIPLIER_MULH_EN
          high_d   = High;
`endif
          prod_d   = '0;
          cnt_d    = '0;
          state_d  = StRun;
        end
      end
      StRun: begin
        prod_d   = prod_step;
        mplier_d = mplier_q >> 1;
`ifndef SEQ_MULTIPLIER_MULH_EN
        mcand_d  = mcand_q << 1;
`endif
        cnt_d    = cnt_q + 7'd1;
        if (cnt_q == 7'(NumIter - 1)) state_d = StDone;
      end
      StDone: begin
        result_d = prod_sel;
        rwout_d  = rw_q;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Done is registered so it coincides with the freshly loaded Result/RWOut.
  assign done_d = (state_q == StDone);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      rw_q     <= '0;
      prod_q   <= '0;
      result_q <= '0;
      rwout_q  <= '0;
      done_q   <= 1'b0;
`ifdef SEQ_MULTIPLIER_MULH_EN
      high_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      rw_q     <= rw_d;
      prod_q   <= prod_d;
      result_q <= result_d;
      rwout_q  <= rwout_d;
      done_q   <= done_d;
`ifdef SEQ_MULTIPLIER_MULH_EN
      high_q   <= high_d;
`endif
    end
  end

  assign Result = result_q;
  assign RWOut  = rwout_q;
  assign Busy   = (state_q == StRun);
  assign Done   = done_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Randomized self-checking bench for seq_multiplier against a plain-arithmetic product model.
module tb_seq_multiplier;

`ifdef SEQ_MULTIPLIER_MULH_EN
  localparam bit HasMulh = 1'b1;
`else
  localparam bit HasMulh = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Reset, Start, High;
  logic [63:0] BusA, BusB, Result;
  logic [4:0]  RW, RWOut;
  logic        Busy, Done;

  int errs   = 0;
  int checks = 0;

  seq_multiplier dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .Start  (Start),
    .BusA   (BusA),
    .BusB   (BusB),
    .RW     (RW),
`ifdef SEQ_MULTIPLIER_MULH_EN
    .High   (High),
`endif
    .Result (Result),
    .RWOut  (RWOut),
    .Busy   (Busy),
    .Done   (Done)
  );

  always #5 Clk = ~Clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  function automatic logic [63:0] rand64();
    return {$urandom, $urandom};
  endfunction

  function automatic logic [63:0] model(input logic [63:0] a, input logic [63:0] b,
                                        input bit hi);
    logic [127:0] p;
    p = {64'd0, a} * {64'd0, b};
    return (HasMulh && hi) ? p[127:64] : p[63:0];
  endfunction

  // Issue one operation; returns when Done is seen (cycle after edge E+65) or the budget expires.
  // With hold set, Start stays high and the buses keep changing during the run.
  task automatic do_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                       input logic [4:0] rw, input bit hi, input bit hold,
                       output logic [63:0] a_nxt, output logic [63:0] b_nxt,
                       output logic [4:0] rw_nxt);
    logic [63:0] prev;
    int          lat, busy_cnt;
    bit          stable;
    prev   = Result;
    Start  = 1'b1;
    BusA   = a;
    BusB   = b;
    RW     = rw;
    High   = hi;
    tick;
    Start  = hold;
    BusA   = rand64();
    BusB   = rand64();
    RW     = 5'($urandom);
    High   = ~hi;
    lat      = 0;
    busy_cnt = 0;
    stable   = 1'b1;
    for (int k = 1; k <= 200 && lat == 0; k++) begin
      if (Busy) busy_cnt++;
      tick;
      if (Done) lat = k;
      else begin
        if (Result !== prev) stable = 1'b0;
        BusA = rand64();
        BusB = rand64();
        RW   = 5'($urandom);
      end
    end
    a_nxt  = BusA;
    b_nxt  = BusB;
    rw_nxt = RW;
    check_eq({tag, " latency"}, 64'(lat), 64'd65);
    check_eq({tag, " busy"}, 64'(busy_cnt), 64'd64);
    check_eq({tag, " held"}, 64'(stable), 64'd1);
    check_eq({tag, " result"}, Result, model(a, b, hi));
    check_eq({tag, " rwout"}, 64'(RWOut), 64'(rw));
  endtask

  // One cycle after the Done pulse: pulse must be gone and outputs held.
  task automatic after_done(input string tag, input logic [63:0] exp_res,
                            input logic [4:0] exp_rw);
    Start = 1'b0;
    tick;
    check_eq({tag, " done1cyc"}, 64'(Done), 64'd0);
    check_eq({tag, " hold res"}, Result, exp_res);
    check_eq({tag, " hold rw"}, 64'(RWOut), 64'(exp_rw));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [63:0] an, bn, t0, t1;
    logic [4:0]  rn;
    logic [63:0] a, b;
    logic [4:0]  r;
    bit          h;

    Reset = 1'b1; Start = 1'b0; High = 1'b0; BusA = '0; BusB = '0; RW = '0;
    tick;
    tick;
    check_eq("rst result", Result, 64'd0);
    check_eq("rst rwout", 64'(RWOut), 64'd0);
    check_eq("rst busy", 64'(Busy), 64'd0);
    check_eq("rst done", 64'(Done), 64'd0);

    // Reset wins over Start.
    Start = 1'b1; BusA = 64'd1; BusB = 64'd1;
    tick;
    check_eq("rst prio busy", 64'(Busy), 64'd0);

    // Start in the first cycle after reset deasserts.
    Reset = 1'b0;
    do_op("3x5", 64'd3, 64'd5, 5'd7, 1'b0, 1'b0, an, bn, rn);
    after_done("3x5", 64'd15, 5'd7);

    do_op("max lo", '1, '1, 5'd1, 1'b0, 1'b0, an, bn, rn);
    after_done("max lo", 64'd1, 5'd1);
    if (HasMulh) begin
      do_op("max hi", '1, '1, 5'd2, 1'b1, 1'b0, an, bn, rn);
      after_done("max hi", 64'hFFFF_FFFF_FFFF_FFFE, 5'd2);
    end

    do_op("zero", 64'h1234, 64'd0, 5'd3, 1'b0, 1'b0, an, bn, rn);
    after_done("zero", 64'd0, 5'd3);

    // Start held high with moving buses: second op takes bus values in the Done cycle.
    do_op("hold1", 64'hDEAD_BEEF, 64'h77, 5'd9, 1'b0, 1'b1, an, bn, rn);
    do_op("hold2", an, bn, rn, 1'b0, 1'b0, a, b, r);
    after_done("hold2", model(an, bn, 1'b0), rn);

    // Abort mid-run: no Done, all outputs cleared, fresh op works.
    Start = 1'b1; BusA = 64'd11; BusB = 64'd13; RW = 5'd4;
    tick;
    Start = 1'b0;
    repeat (30) tick;
    Reset = 1'b1;
    tick;
    Reset = 1'b0;
    check_eq("abort result", Result, 64'd0);
    check_eq("abort rwout", 64'(RWOut), 64'd0);
    check_eq("abort busy", 64'(Busy), 64'd0);
    check_eq("abort done", 64'(Done), 64'd0);
    do_op("2x9", 64'd2, 64'd9, 5'd5, 1'b0, 1'b0, an, bn, rn);
    after_done("2x9", 64'd18, 5'd5);

    // Back-to-back: the second Start lands in the Done cycle, giving a 66-cycle period.
    do_op("b2b 2x3", 64'd2, 64'd3, 5'd10, 1'b0, 1'b0, an, bn, rn);
    t0 = 64'($time);
    do_op("b2b 4x4", 64'd4, 64'd4, 5'd11, 1'b0, 1'b0, an, bn, rn);
    t1 = 64'($time);
    check_eq("b2b period", (t1 - t0) / 64'd10, 64'd66);
    after_done("b2b 4x4", 64'd16, 5'd11);

    for (int i = 0; i < 8; i++) begin
      a = rand64();
      b = (i == 0) ? 64'd1 : rand64();
      r = 5'($urandom);
      h = 1'($urandom);
      do_op("rand", a, b, r, h, 1'b0, an, bn, rn);
      after_done("rand", model(a, b, h), r);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
